pipe_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor for wide operands.
- The operand is split into STAGES slices. Each slice is built from BLK-bit lookahead groups, with group carries rippled within the slice.
- The carry between slices is registered, so one add/sub is accepted per cycle with STAGES-cycle latency.
- Sits in the datapath as the streaming successor of the 4-bit lookahead cell, with a valid/ready handshake toward producer and consumer.

---
 rtl/pipe_cla_adder_if.sv | 47 ++++
 rtl/pipe_cla_adder.sv | 150 +++++++++++++++
 tb/tb_pipe_cla_adder.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_cla_adder_if.sv
// Streaming handshake and operand/result bus for pipe_cla_adder.
// master: producer/consumer side; slave: the adder.
interface pipe_cla_adder_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid,
    output a,
    output b,
    output cin,
    output sub,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  sum,
    input  cout,
    input  ovf
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  cin,
    input  sub,
    input  out_ready,
    output in_ready,
    output out_valid,
    output sum,
    output cout,
    output ovf
  );

endinterface

// File: rtl/pipe_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// The operand is cut into STAGES slices of SW bits; each stage resolves one slice
// with BLK-bit lookahead groups (group carries ripple inside the slice) and
// registers the partial sum, the slice carry-out and the untouched upper operand bits.
// WIDTH must be divisible by STAGES, and WIDTH/STAGES by BLK.
module pipe_cla_adder #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned BLK    = 4
) (
  input logic              clk,
  input logic              rst,
  pipe_cla_adder_if.slave  bus
);

  localparam int unsigned SW   = WIDTH / STAGES;
  localparam int unsigned NGRP = SW / BLK;

  logic             en;
  logic             last_valid;
  logic [WIDTH-1:0] bb_in;
  logic             c0_in;

  // The whole pipe advances or holds as one; no bubble collapsing.
  always_comb begin
    en = ~last_valid | bus.out_ready;
  end

  assign bus.in_ready  = en;
  assign bus.out_valid = last_valid;

  // Subtraction is a + ~b + 1, so cin is overridden when sub is set.
  always_comb begin
    bb_in = bus.sub ? ~bus.b : bus.b;
    c0_in = bus.sub ? 1'b1 : bus.cin;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // Operand bits still to be processed at this stage, and sum bits known after it.
    localparam int unsigned RemW  = WIDTH - s * SW;
    localparam int unsigned DoneW = (s + 1) * SW;

    logic [RemW-1:0]  a_in;
    logic [RemW-1:0]  b_in;
    logic             c_in;
    logic             v_in;
    logic [DoneW-1:0] sum_d;

    logic [SW-1:0]    p;
    logic [SW-1:0]    g;
    logic [SW:0]      c;
    logic [SW-1:0]    sl_sum;
    logic             cj;
    logic             term;

    logic             valid_q;
    logic             carry_q;
    logic [DoneW-1:0] sum_q;

    if (s == 0) begin : g_src
      assign a_in  = bus.a;
      assign b_in  = bb_in;
      assign c_in  = c0_in;
      assign v_in  = bus.in_valid;
      assign sum_d = sl_sum;
    end else begin : g_src
      assign a_in  = g_stage[s-1].g_fwd.a_q;
      assign b_in  = g_stage[s-1].g_fwd.b_q;
      assign c_in  = g_stage[s-1].carry_q;
      assign v_in  = g_stage[s-1].valid_q;
      assign sum_d = {sl_sum, g_stage[s-1].sum_q};
    end

    // Slice adder: each group carry is a flat sum of products of its group
    // carry-in, p and g; only the group carry-outs ripple.
    always_comb begin
      p    = a_in[SW-1:0] ^ b_in[SW-1:0];
      g    = a_in[SW-1:0] & b_in[SW-1:0];
      c    = '0;
      cj   = 1'b0;
      term = 1'b0;
      c[0] = c_in;
      for (int grp = 0; grp < int'(NGRP); grp++) begin
        for (int j = 0; j < int'(BLK); j++) begin
          // Propagate-chain term from the group carry-in.
          term = c[grp * int'(BLK)];
          for (int m = 0; m <= j; m++) begin
            term = term & p[grp * int'(BLK) + m];
          end
          cj = term;
          // Generate terms from each lower bit of the group.
          for (int i = 0; i <= j; i++) begin
            term = g[grp * int'(BLK) + i];
            for (int m = i + 1; m <= j; m++) begin
              term = term & p[grp * int'(BLK) + m];
            end
            cj = cj | term;
          end
          c[grp * int'(BLK) + j + 1] = cj;
        end
      end
      sl_sum = p ^ c[SW-1:0];
    end

    // Stage register: valid bit, partial sum and slice carry-out.
    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (en) begin
        valid_q <= v_in;
        carry_q <= c[SW];
        sum_q   <= sum_d;
      end
    end

    if (s < STAGES - 1) begin : g_fwd
      localparam int unsigned FwdW = RemW - SW;

      logic [FwdW-1:0] a_q;
      logic [FwdW-1:0] b_q;

      // Carry the unprocessed upper operand bits forward; don't-care when invalid.
      always_ff @(posedge clk) begin
        if (en) begin
          a_q <= a_in[RemW-1:SW];
          b_q <= b_in[RemW-1:SW];
        end
      end
    end else begin : g_last
      logic ovf_q;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= c[SW-1] ^ c[SW];
        end
      end

      assign last_valid = valid_q;
      assign bus.sum    = sum_q;
      assign bus.cout   = carry_q;
      assign bus.ovf    = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipe_cla_adder.sv
// Bench for pipe_cla_adder: directed vectors on the WIDTH=32/STAGES=2/BLK=4 build,
// plus per-build scoreboards for four (STAGES, BLK) builds sharing one stimulus.
module tb_pipe_cla_adder;

  localparam int unsigned W = 32;
  localparam int unsigned CfgStages [4] = '{2, 1, 4, 2};
  localparam int unsigned CfgBlk    [4] = '{4, 4, 4, 8};

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_ready;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: plain wide addition; packs {sum, cout, ovf}.
  function automatic logic [W+1:0] model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                         input logic fcin, input logic fsub);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         v;
    bb = fsub ? ~fb : fb;
    r  = {1'b0, fa} + {1'b0, bb} + {{W{1'b0}}, (fsub ? 1'b1 : fcin)};
    v  = (fa[W-1] == bb[W-1]) && (r[W-1] != fa[W-1]);
    return {r[W-1:0], r[W], v};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(7))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7fff_ffff;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_ffff;
      default: return $urandom();
    endcase
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_cfg
    pipe_cla_adder_if #(.WIDTH(W)) bus ();

    assign bus.in_valid  = in_valid;
    assign bus.a         = a;
    assign bus.b         = b;
    assign bus.cin       = cin;
    assign bus.sub       = sub;
    assign bus.out_ready = out_ready;

    pipe_cla_adder #(
      .WIDTH  (W),
      .STAGES (CfgStages[i]),
      .BLK    (CfgBlk[i])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    logic [W+1:0] exp_q [$];
    logic [W+1:0] exp_v;

    // Scoreboard: sampled mid-cycle, acting on the handshakes of the coming edge.
    always @(negedge clk) begin
      if (rst) begin
        exp_q.delete();
      end else begin
        if (bus.out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq($sformatf("sb%0d_spurious", i), 64'(bus.out_valid), 64'd0);
          end else begin
            exp_v = exp_q.pop_front();
            check_eq($sformatf("sb%0d_result", i), 64'({bus.sum, bus.cout, bus.ovf}),
                     64'(exp_v));
          end
        end
        if (in_valid && bus.in_ready) begin
          exp_q.push_back(model(a, b, cin, sub));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operand through an otherwise empty 2-stage pipe; result checked after edge N+1.
  task automatic apply_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tcin, input logic tsub, input logic [W-1:0] esum,
                           input logic ecout, input logic eovf);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    cin       = tcin;
    sub       = tsub;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq({tag, "_early"}, 64'(g_cfg[0].bus.out_valid), 64'd0);
    step();
    check_eq({tag, "_valid"}, 64'(g_cfg[0].bus.out_valid), 64'd1);
    check_eq({tag, "_sum"}, 64'(g_cfg[0].bus.sum), 64'(esum));
    check_eq({tag, "_cout"}, 64'(g_cfg[0].bus.cout), 64'(ecout));
    check_eq({tag, "_ovf"}, 64'(g_cfg[0].bus.ovf), 64'(eovf));
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();
    check_eq("rst_valid", 64'(g_cfg[0].bus.out_valid), 64'd0);
    check_eq("rst_sum", 64'(g_cfg[0].bus.sum), 64'd0);
    check_eq("rst_cout", 64'(g_cfg[0].bus.cout), 64'd0);
    check_eq("rst_ovf", 64'(g_cfg[0].bus.ovf), 64'd0);
    check_eq("rst_ready", 64'(g_cfg[0].bus.in_ready), 64'd1);
    rst = 1'b0;
    step();

    apply_one("wrap", 32'hffff_ffff, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    apply_one("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7fff_ffff, 1'b1, 1'b1);
    apply_one("sub_brw", 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hffff_ffff, 1'b0, 1'b0);
    apply_one("cin_ovf", 32'h7fff_ffff, 32'h0000_0000, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    apply_one("mixed", 32'h1234_5678, 32'h0000_ffff, 1'b0, 1'b0, 32'h1235_5677, 1'b0, 1'b0);
    apply_one("sub_cin", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

    // Back-to-back stream of 8 operands; operand k is k*0x11111111 + k.
    out_ready = 1'b1;
    cin       = 1'b0;
    sub       = 1'b0;
    for (int j = 0; j < 10; j++) begin
      if (j < 8) begin
        in_valid = 1'b1;
        a        = 32'(j) * 32'h1111_1111;
        b        = 32'(j);
        #1;
        check_eq("strm_ready", 64'(g_cfg[0].bus.in_ready), 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (j >= 1 && j <= 8) begin
        check_eq("strm_valid", 64'(g_cfg[0].bus.out_valid), 64'd1);
        check_eq("strm_sum", 64'(g_cfg[0].bus.sum),
                 64'(32'(j - 1) * 32'h1111_1111 + 32'(j - 1)));
      end else if (j == 9) begin
        check_eq("strm_end", 64'(g_cfg[0].bus.out_valid), 64'd0);
      end
    end

    // Stall: X0 at the output, X1 in flight, X2 waiting at the input.
    in_valid = 1'b1; a = 32'hffff_ffff; b = 32'hffff_ffff; cin = 1'b1; sub = 1'b0;
    step();
    a = 32'h7fff_ffff; b = 32'hffff_ffff; cin = 1'b0; sub = 1'b1;
    step();
    out_ready = 1'b0;
    a = 32'h0000_ffff; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
    #1;
    check_eq("stall_rdy0", 64'(g_cfg[0].bus.in_ready), 64'd0);
    for (int j = 0; j < 3; j++) begin
      step();
      check_eq("stall_valid", 64'(g_cfg[0].bus.out_valid), 64'd1);
      check_eq("stall_hold", 64'({g_cfg[0].bus.sum, g_cfg[0].bus.cout, g_cfg[0].bus.ovf}),
               64'({32'hffff_ffff, 1'b1, 1'b0}));
      check_eq("stall_rdy", 64'(g_cfg[0].bus.in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("release_rdy", 64'(g_cfg[0].bus.in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    check_eq("rel_x1", 64'({g_cfg[0].bus.out_valid, g_cfg[0].bus.sum, g_cfg[0].bus.cout,
                            g_cfg[0].bus.ovf}), 64'({1'b1, 32'h8000_0000, 1'b0, 1'b1}));
    step();
    check_eq("rel_x2", 64'({g_cfg[0].bus.out_valid, g_cfg[0].bus.sum, g_cfg[0].bus.cout,
                            g_cfg[0].bus.ovf}), 64'({1'b1, 32'h0001_0000, 1'b0, 1'b0}));
    step();
    check_eq("rel_empty", 64'(g_cfg[0].bus.out_valid), 64'd0);

    // Reset with two operations in flight.
    in_valid = 1'b1; a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0;
    step();
    a = 32'd3; b = 32'd4;
    step();
    check_eq("inflight", 64'(g_cfg[0].bus.out_valid), 64'd1);
    rst      = 1'b1;
    in_valid = 1'b0;
    step();
    check_eq("rst_mid", 64'(g_cfg[0].bus.out_valid), 64'd0);
    rst = 1'b0;
    for (int j = 0; j < 4; j++) begin
      step();
      check_eq("rst_stale", 64'(g_cfg[0].bus.out_valid), 64'd0);
    end

    // Random traffic; every build is checked by its own scoreboard.
    for (int k = 0; k < 3000; k++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      a         = pick();
      b         = pick();
      cin       = 1'($urandom_range(1));
      sub       = 1'($urandom_range(1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    check_eq("drain0", 64'(g_cfg[0].exp_q.size()), 64'd0);
    check_eq("drain1", 64'(g_cfg[1].exp_q.size()), 64'd0);
    check_eq("drain2", 64'(g_cfg[2].exp_q.size()), 64'd0);
    check_eq("drain3", 64'(g_cfg[3].exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
